instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch (IF) stage of the pipelined MIPS core. Owns the program counter, drives the byte address into the combinational, big-endian instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. Supports load-use stall hold, ID-resolved branch redirect with squash, and a halt on illegal fetch addresses.

## Interface
- RESET_PC, 32'd100: PC value loaded on reset (first test program address).
- MEM_BYTES, 16384: instruction memory size in bytes; legal PCs are 0 .. MEM_BYTES-4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- PC  out  32  byte address to instruction memory; registered.
- instruction  in  32  word returned by instruction memory for the current PC, valid in the same cycle.
- stall  in  1  hazard-unit hold (load-use); freezes PC and IF/ID.
- branch_taken  in  1  ID-stage redirect request.
- branch_target  in  32  redirect byte address, sampled when branch_taken=1.
- if_id_instr  out  32  IF/ID instruction; 0 (NOP) when bubble.
- if_id_pc4  out  32  IF/ID PC+4 of the captured instruction; 0 when bubble.
- if_id_valid  out  1  IF/ID holds a real instruction.
- pc_fault  out  1  sticky; PC became misaligned or out of range.
- fetch_count  out  32  number of valid instructions loaded into IF/ID since reset.

## Operation
- State machine: BOOT, RUN, HALT. Reset state BOOT.
- BOOT: one cycle after rst deasserts; PC held at RESET_PC, IF/ID not loaded; unconditionally -> RUN.
- RUN, per rising edge, priority highest first:
  - fault: PC[1:0]!=0 or PC > MEM_BYTES-4 -> HALT, pc_fault<=1, IF/ID<=bubble, PC held.
  - stall=1: PC, IF/ID, fetch_count held; branch_taken ignored.
  - branch_taken=1: PC<=branch_target; IF/ID<=bubble (instruction fetched this cycle squashed, no delay slot); fetch_count held.
  - otherwise: if_id_instr<=instruction, if_id_pc4<=PC+4, if_id_valid<=1, PC<=PC+4, fetch_count<=fetch_count+1.
- HALT: all registers held except IF/ID forced to bubble; exit only via rst.
- Bubble = if_id_instr 0, if_id_pc4 0, if_id_valid 0.
- Fault check uses the current PC only; a bad branch_target is accepted into PC and faults on the following edge.
- PC+4 and fetch_count are modulo 2^32; no saturation.

## Timing
- Reset values (immediate on rst rise, no clock needed): PC=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, pc_fault=0, fetch_count=0, state BOOT.
- Fetch latency: instruction at PC=A appears on if_id_instr one edge after PC=A is presented (memory is combinational).
- Throughput one instruction per cycle in RUN with stall=0, branch_taken=0.
- Branch penalty: exactly one bubble cycle; target instruction reaches IF/ID two edges after branch_taken sampled.
- Stall held N cycles freezes outputs N cycles; release resumes from the same PC with no loss or duplication.
- rst asserted mid-operation aborts everything; after deassert, first valid IF/ID load occurs on the second rising edge (BOOT then RUN).
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset/sequential: memory word 0x48080000 at 100, 0x48090004 at 104; release rst -> edge1 BOOT (PC=100, valid=0); edge2 if_id_instr=0x48080000, pc4=104, PC=104; edge3 0x48090004, pc4=108, fetch_count=2.
- Stall: at PC=216 hold stall 2 cycles -> PC stays 216, IF/ID and fetch_count unchanged; after release next load is word at 216 with pc4=220.
- Branch: at PC=520, branch_taken=1, target=500 -> next edge PC=500, if_id_valid=0, if_id_instr=0; following edge if_id_instr=0x24130000|word at 500, pc4=504.
- Stall+branch same cycle: stall=1, branch_taken=1, target=500 at PC=520 -> PC stays 520, IF/ID held.
- Fault: branch to 502 -> PC=502, next edge pc_fault=1, HALT, valid=0; repeat with target 16384; stays halted 10 cycles; rst clears pc_fault and PC=100.
- Async reset: assert rst mid-cycle while fetch_count=7 -> all outputs reach reset values before next edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, captures the fetched word into IF/ID.
// Handles load-use hold, ID branch redirect with squash, and halt on bad PC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd100,
  parameter int          MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        pc_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] instr_n;
  logic [31:0] pc4_n;
  logic        valid_n;
  logic        fault_n;
  logic [31:0] cnt_n;
  logic        bad_pc;

  assign bad_pc = (PC[1:0] != 2'b00) || (PC > PC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      PC          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      pc_fault    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      PC          <= pc_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
      if_id_valid <= valid_n;
      pc_fault    <= fault_n;
      fetch_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = PC;
    instr_n = if_id_instr;
    pc4_n   = if_id_pc4;
    valid_n = if_id_valid;
    fault_n = pc_fault;
    cnt_n   = fetch_count;
    unique case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        // stall outranks redirect: ID is frozen, so its branch is not final
        if (bad_pc) begin
          state_n = HALT;
          fault_n = 1'b1;
          instr_n = '0;
          pc4_n   = '0;
          valid_n = 1'b0;
        end else if (stall) begin
          pc_n = PC;
        end else if (branch_taken) begin
          pc_n    = branch_target;
          instr_n = '0;
          pc4_n   = '0;
          valid_n = 1'b0;
        end else begin
          instr_n = instruction;
          pc4_n   = PC + 32'd4;
          valid_n = 1'b1;
          pc_n    = PC + 32'd4;
          cnt_n   = fetch_count + 32'd1;
        end
      end
      HALT: begin
        instr_n = '0;
        pc4_n   = '0;
        valid_n = 1'b0;
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: reference model pushes
// expected IF state each edge, a negedge monitor pops and compares.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        pc_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [4096];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_fault, m_boot, m_halt;

  always #5 clk = ~clk;

  assign instruction = (PC < 32'd16384) ? mem[PC[13:2]] : 32'h0;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .instruction  (instruction),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .pc_fault     (pc_fault),
    .fetch_count  (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic void model_reset();
    m_pc = 32'd100;
    m_instr = 0;
    m_pc4 = 0;
    m_cnt = 0;
    m_valid = 0;
    m_fault = 0;
    m_boot = 1;
    m_halt = 0;
  endfunction

  function automatic void bubble();
    m_instr = 0;
    m_pc4 = 0;
    m_valid = 0;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_edge(input logic s, input logic b,
                                     input logic [31:0] t);
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      bubble();
    end else if ((m_pc % 4) != 0 || m_pc > 32'd16380) begin
      m_halt = 1;
      m_fault = 1;
      bubble();
    end else if (s) begin
    end else if (b) begin
      m_pc = t;
      bubble();
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4 = m_pc + 4;
      m_pc = m_pc + 4;
      m_cnt = m_cnt + 1;
      m_valid = 1;
    end
  endfunction

  task automatic step(input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    stall = s;
    branch_taken = b;
    branch_target = t;
    @(posedge clk);
    model_edge(s, b, t);
    e.pc = m_pc;
    e.instr = m_instr;
    e.pc4 = m_pc4;
    e.cnt = m_cnt;
    e.valid = m_valid;
    e.fault = m_fault;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Reset lands mid low-phase; outputs must clear with no clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", PC, 32'd100);
    chk("rst_instr", if_id_instr, 0);
    chk("rst_pc4", if_id_pc4, 0);
    chk("rst_valid", {31'd0, if_id_valid}, 0);
    chk("rst_fault", {31'd0, pc_fault}, 0);
    chk("rst_cnt", fetch_count, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", PC, e.pc);
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_pc4", if_id_pc4, e.pc4);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      chk("pc_fault", {31'd0, pc_fault}, {31'd0, e.fault});
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[25]   = 32'h48080000;
    mem[26]   = 32'h48090004;
    mem[125]  = 32'h24130000 | (mem[125] & 32'h0000ffff);
    stall = 0;
    branch_taken = 0;
    branch_target = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("por_pc", PC, 32'd100);
    chk("por_valid", {31'd0, if_id_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // boot, then sequential fetch up to PC=216
    run(30);
    chk("pc_at_216", m_pc, 32'd216);
    step(1, 0, 0);
    step(1, 1, 32'd300);
    run(2);

    // redirect to 520, stall+branch, then branch to 500
    step(0, 1, 32'd520);
    step(1, 1, 32'd500);
    step(0, 1, 32'd500);
    run(3);

    // randomized traffic with aligned in-range targets
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           32'($urandom_range(0, 4095)) << 2);

    // misaligned target faults on the following edge, stays halted
    step(0, 1, 32'd502);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 32'd100);
    do_reset();

    // last legal word, then natural fall-off past the end
    run(1);
    step(0, 1, 32'd16380);
    run(4);
    do_reset();

    // out-of-range target
    run(3);
    step(0, 1, 32'd16384);
    run(12);
    do_reset();

    // async reset with fetch_count=7
    run(8);
    chk("cnt_before_rst", fetch_count, 32'd7);
    do_reset();
    run(5);

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
